pwm_deadtime_gen: RTL

Complementary-output stage that sits directly downstream of the single-ended PWM generator. It consumes the raw PWM waveform and produces a high-side and low-side gate-drive pair, with a programmable dead time inserted at every transition. The two outputs are never asserted together. Input pulses shorter than the dead time are absorbed and flagged. The block feeds half-bridge drivers.

---
 rtl/pwm_deadtime_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate-drive stage with programmable dead time at every transition.
// Latency: 2 cycles input-to-outgoing-drop, 2+D cycles to incoming rise; no backpressure (free-running stream).
module pwm_deadtime_gen #(
    parameter int DT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                dt_active,
    output logic                pulse_drop
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DT    = 2'd1,
        S_HI_ON = 2'd2,
        S_LO_ON = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q;
    logic                pwm_s_q;
    logic                target_q, target_d;
    logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
    logic                pwm_hi_q, pwm_hi_d;
    logic                pwm_lo_q, pwm_lo_d;
    logic                dt_active_q, dt_active_d;
    logic                pulse_drop_q, pulse_drop_d;
    logic [DT_WIDTH-1:0] dt_eff;

    // A zero setting would leave no gap at all, so it is stretched to one cycle.
    assign dt_eff = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        dt_cnt_d     = dt_cnt_q;
        pulse_drop_d = 1'b0;
        if (!en) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d  = S_DT;
                    target_d = pwm_s_q;
                    dt_cnt_d = dt_eff;
                end
                S_HI_ON: begin
                    if (!pwm_s_q) begin
                        state_d  = S_DT;
                        target_d = 1'b0;
                        dt_cnt_d = dt_eff;
                    end
                end
                S_LO_ON: begin
                    if (pwm_s_q) begin
                        state_d  = S_DT;
                        target_d = 1'b1;
                        dt_cnt_d = dt_eff;
                    end
                end
                S_DT: begin
                    // A reversal inside the gap restarts it, so short pulses never reach the bridge.
                    if (pwm_s_q != target_q) begin
                        target_d     = pwm_s_q;
                        dt_cnt_d     = dt_eff;
                        pulse_drop_d = 1'b1;
                    end else if (dt_cnt_q == DT_WIDTH'(1)) begin
                        state_d = target_q ? S_HI_ON : S_LO_ON;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // Outputs decode the next state so they are registered alongside it.
    always_comb begin
        pwm_hi_d    = (state_d == S_HI_ON);
        pwm_lo_d    = (state_d == S_LO_ON);
        dt_active_d = (state_d == S_DT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            pwm_s_q      <= 1'b0;
            state_q      <= S_OFF;
            target_q     <= 1'b0;
            dt_cnt_q     <= '0;
            pwm_hi_q     <= 1'b0;
            pwm_lo_q     <= 1'b0;
            dt_active_q  <= 1'b0;
            pulse_drop_q <= 1'b0;
        end else begin
            sync1_q      <= pwm_in;
            pwm_s_q      <= sync1_q;
            state_q      <= state_d;
            target_q     <= target_d;
            dt_cnt_q     <= dt_cnt_d;
            pwm_hi_q     <= pwm_hi_d;
            pwm_lo_q     <= pwm_lo_d;
            dt_active_q  <= dt_active_d;
            pulse_drop_q <= pulse_drop_d;
        end
    end

    assign pwm_hi     = pwm_hi_q;
    assign pwm_lo     = pwm_lo_q;
    assign dt_active  = dt_active_q;
    assign pulse_drop = pulse_drop_q;

endmodule
